dht11_poll_sched: RTL

- Scheduler that sequences a start-triggered DHT11 reader on behalf of two requesters (display, UART) plus an internal auto-poll timer.
- Enforces the sensor's minimum inter-read gap, retries failed reads, and holds the last good measurement.
- One read serves every requester pending at its start. Sits between the sensor reader and the consumers.

---
 rtl/dht11_poll_sched.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/dht11_poll_sched.sv
// DHT11 read scheduler: merges display, UART and auto-poll requests into
// gap-limited reads with watchdog, retry, and last-good-measurement hold.
module dht11_poll_sched #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int MIN_GAP_MS = 2000,
    parameter int AUTO_MS    = 5000,
    parameter int TIMEOUT_MS = 50,
    parameter int RETRY_MAX  = 3,
    parameter int STALE_MS   = 10000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [1:0]  req,
    input  logic        auto_en,
    output logic [1:0]  ack,
    output logic        ack_err,
    output logic        rd_start,
    input  logic        rd_done,
    input  logic        rd_err,
    input  logic [31:0] rd_data,
    output logic [31:0] meas_data,
    output logic        data_valid,
    output logic        stale,
    output logic        busy,
    output logic [7:0]  fail_cnt
);

    localparam int TICK_DIV = CLK_FREQ / 1000;
    localparam int PRE_W    = $clog2(TICK_DIV + 2);
    localparam int GAP_W    = $clog2(MIN_GAP_MS + 2);
    localparam int AUTO_W   = $clog2(AUTO_MS + 2);
    localparam int WDOG_W   = $clog2(TIMEOUT_MS + 2);
    localparam int RETRY_W  = $clog2(RETRY_MAX + 2);
    localparam int AGE_W    = $clog2(STALE_MS + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_DONE,
        S_FAIL
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PRE_W-1:0]    pre_cnt;
    logic                ms_tick;
    logic [GAP_W-1:0]    gap_cnt;
    logic                gap_ok;
    logic [AUTO_W-1:0]   auto_cnt;
    logic                auto_fire;
    logic [2:0]          pend;
    logic [2:0]          svc;
    logic [WDOG_W-1:0]   wdog;
    logic                wdog_exp;
    logic [RETRY_W-1:0]  retry_cnt;
    logic                retry_left;
    logic                fail_final;
    logic                retire;
    logic                read_ok;
    logic [31:0]         rd_buf;
    logic [AGE_W-1:0]    age;

    // ---------------------------------------------------------------- ms tick
    assign ms_tick = (pre_cnt == PRE_W'(TICK_DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pre_cnt <= '0;
        end else if (ms_tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // ------------------------------------------------------------- gap timer
    assign gap_ok = (gap_cnt == GAP_W'(MIN_GAP_MS));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gap_cnt <= '0;
        end else if (state == S_START) begin
            gap_cnt <= '0;
        end else if (ms_tick && !gap_ok) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
        end
    end

    // ------------------------------------------------------------ auto timer
    assign auto_fire = auto_en && ms_tick && (auto_cnt == AUTO_W'(AUTO_MS - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            auto_cnt <= '0;
        end else if (!auto_en) begin
            auto_cnt <= '0;
        end else if (ms_tick) begin
            auto_cnt <= auto_fire ? '0 : auto_cnt + AUTO_W'(1);
        end
    end

    // ---------------------------------------------------------------- FSM
    assign wdog_exp   = (wdog == WDOG_W'(TIMEOUT_MS));
    assign retry_left = (retry_cnt < RETRY_W'(RETRY_MAX));
    assign fail_final = (state == S_FAIL) && !retry_left;
    assign retire     = (state == S_DONE) || fail_final;
    // An error or watchdog expiry outranks a coincident success pulse.
    assign read_ok    = (state == S_BUSY) && rd_done && !rd_err && !wdog_exp;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns each output -- no latches.
        state_nxt = state;
        rd_start  = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                if ((|pend) && gap_ok) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                rd_start  = 1'b1;
                busy      = 1'b1;
                state_nxt = S_BUSY;
            end
            S_BUSY: begin
                busy = 1'b1;
                if (rd_err || wdog_exp) begin
                    state_nxt = S_FAIL;
                end else if (rd_done) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_FAIL:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ----------------------------------------------- pending / service sets
    // New requests win over the retire clear so a late requester gets the next read.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pend <= '0;
            svc  <= '0;
        end else begin
            pend <= (pend & ~(retire ? svc : 3'b000)) | {auto_fire, req};
            if (state == S_START) begin
                svc <= pend;
            end
        end
    end

    // ------------------------------------------------- watchdog and retries
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wdog      <= '0;
            retry_cnt <= '0;
        end else begin
            if (state == S_START) begin
                wdog <= '0;
            end else if ((state == S_BUSY) && ms_tick && !wdog_exp) begin
                wdog <= wdog + WDOG_W'(1);
            end

            if (retire) begin
                retry_cnt <= '0;
            end else if ((state == S_FAIL) && retry_left) begin
                retry_cnt <= retry_cnt + RETRY_W'(1);
            end
        end
    end

    // ------------------------------------------------------ result registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_buf     <= '0;
            ack        <= '0;
            ack_err    <= 1'b0;
            meas_data  <= '0;
            data_valid <= 1'b0;
            fail_cnt   <= '0;
        end else begin
            ack     <= '0;
            ack_err <= 1'b0;
            if (read_ok) begin
                rd_buf <= rd_data;
            end
            if (state == S_DONE) begin
                ack        <= svc[1:0];
                meas_data  <= rd_buf;
                data_valid <= 1'b1;
            end else if (fail_final) begin
                ack     <= svc[1:0];
                ack_err <= 1'b1;
                if (fail_cnt != 8'hFF) begin
                    fail_cnt <= fail_cnt + 8'd1;
                end
            end
        end
    end

    // ------------------------------------------------------- data freshness
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            age   <= '0;
            stale <= 1'b1;
        end else begin
            if (state == S_DONE) begin
                age <= '0;
            end else if (ms_tick && (age != AGE_W'(STALE_MS))) begin
                age <= age + AGE_W'(1);
            end
            stale <= !data_valid || (age == AGE_W'(STALE_MS));
        end
    end

endmodule
